// File: rtl/i2s_tx_10xe_axil_pkg.sv
// Shared types and constants for the I2S TX control-bus AXI4-Lite master.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: FSM state enum, AXI response codes, default bus widths,
//           default-width request struct, wait-state helper.
package i2s_tx_10xe_axil_pkg;

  localparam int unsigned AXIL_ADDR_W = 8;
  localparam int unsigned AXIL_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,       // AW and W both outstanding or one of them still pending
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  // Request as seen by a requester port at the default bus widths.
  typedef struct packed {
    logic                   wr;
    logic [AXIL_ADDR_W-1:0] addr;
    logic [AXIL_DATA_W-1:0] wdata;
  } axil_req_t;

  // States in which the master waits on the slave and the watchdog runs.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_WR) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/i2s_tx_10xe_rr_arb2.sv
// Two-input round-robin arbiter with a combinational grant.
// Latency: grant is combinational from req_vld; pointer updates one cycle after upd_vld.
// Backpressure: none; the grant is simply held until the owner updates the pointer.
// Ports: clk/rst (sync active-high), req_vld[1:0] requests, upd_vld/upd_idx record
//        the last served port, gnt_vld/gnt_idx current grant.
module i2s_tx_10xe_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_vld,
  input  logic       upd_vld,
  input  logic       upd_idx,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  // last_q holds the port served most recently; resetting it to 1 makes
  // port 0 win the first contended grant.
  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (upd_vld) begin
      last_d = upd_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt_vld = |req_vld;
    case (req_vld)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_q;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/i2s_tx_10xe_axil_ctrl_master.sv
// AXI4-Lite master owning the I2S TX control bus, shared by two requester ports.
// Latency: zero-wait slave gives AW/W or AR at +1, B or R at +2, rsp_valid at +3 from acceptance.
// Backpressure: req_ready only in IDLE for the granted port; rsp has none (one-cycle pulse).
// Ports: req_* (2 packed ports), rsp_* (completion), m_axi_ctrl_* (AXI4-Lite master),
//        busy (not IDLE), timeout_o (one pulse per stalled phase).
module i2s_tx_10xe_axil_ctrl_master
  import i2s_tx_10xe_axil_pkg::*;
#(
  parameter int unsigned ADDR_W         = AXIL_ADDR_W,
  parameter int unsigned DATA_W         = AXIL_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                s_axi_ctrl_aclk,
  input  logic                s_axi_ctrl_areset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_wr,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                m_axi_ctrl_awvalid,
  input  logic                m_axi_ctrl_awready,
  output logic [ADDR_W-1:0]   m_axi_ctrl_awaddr,
  output logic                m_axi_ctrl_wvalid,
  input  logic                m_axi_ctrl_wready,
  output logic [DATA_W-1:0]   m_axi_ctrl_wdata,
  input  logic                m_axi_ctrl_bvalid,
  output logic                m_axi_ctrl_bready,
  input  logic [1:0]          m_axi_ctrl_bresp,
  output logic                m_axi_ctrl_arvalid,
  input  logic                m_axi_ctrl_arready,
  output logic [ADDR_W-1:0]   m_axi_ctrl_araddr,
  input  logic                m_axi_ctrl_rvalid,
  output logic                m_axi_ctrl_rready,
  input  logic [DATA_W-1:0]   m_axi_ctrl_rdata,
  input  logic [1:0]          m_axi_ctrl_rresp,
  output logic                busy,
  output logic                timeout_o
);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Watchdog counts cycles already spent in the current wait state. The pulse
  // is registered, so it is launched when the count is two short of the limit
  // and appears on the TIMEOUT_CYCLES-th cycle of the phase.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] WD_FIRE = 16'(TIMEOUT_CYCLES - 2);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [15:0]         wd_q, wd_d;
  logic                timeout_q, timeout_d;

  logic gnt_vld;
  logic gnt_idx;
  logic accept;
  logic aw_done;
  logic w_done;
  req_t sel_req;

  i2s_tx_10xe_rr_arb2 u_arb (
    .clk     (s_axi_ctrl_aclk),
    .rst     (s_axi_ctrl_areset),
    .req_vld (req_valid),
    .upd_vld (state_q == ST_DONE),
    .upd_idx (owner_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_req.wr    = gnt_idx ? req_wr[1] : req_wr[0];
    sel_req.addr  = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_req.wdata = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  // Gated by reset so the port never sees ready while the block is held in reset.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == ST_IDLE) && gnt_vld && !s_axi_ctrl_areset) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign accept  = |(req_valid & req_ready);
  // A write channel is finished once its valid is low or it handshakes this cycle.
  assign aw_done = !awvalid_q || m_axi_ctrl_awready;
  assign w_done  = !wvalid_q || m_axi_ctrl_wready;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = gnt_idx;
          if (sel_req.wr) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = sel_req.addr;
            wdata_d   = sel_req.wdata;
          end else begin
            state_d   = ST_RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = sel_req.addr;
          end
        end
      end
      ST_WR: begin
        if (awvalid_q && m_axi_ctrl_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_ctrl_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_ctrl_bvalid) begin
          state_d              = ST_DONE;
          bready_d             = 1'b0;
          rsp_resp_d           = m_axi_ctrl_bresp;
          rsp_rdata_d          = '0;
          rsp_valid_d[owner_q] = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (m_axi_ctrl_arready) begin
          state_d   = ST_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_ctrl_rvalid) begin
          state_d              = ST_DONE;
          rready_d             = 1'b0;
          rsp_resp_d           = m_axi_ctrl_rresp;
          rsp_rdata_d          = m_axi_ctrl_rdata;
          rsp_valid_d[owner_q] = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog: restart on any state change, saturate so the pulse fires once.
    if ((state_d != state_q) || !is_wait_state(state_q)) begin
      wd_d = '0;
    end else if (wd_q != WD_LAST) begin
      wd_d = wd_q + 16'd1;
    end else begin
      wd_d = wd_q;
    end
    timeout_d = is_wait_state(state_q) && (state_d == state_q) && (wd_q == WD_FIRE);
  end

  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (s_axi_ctrl_areset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
    end
  end

  assign m_axi_ctrl_awvalid = awvalid_q;
  assign m_axi_ctrl_awaddr  = awaddr_q;
  assign m_axi_ctrl_wvalid  = wvalid_q;
  assign m_axi_ctrl_wdata   = wdata_q;
  assign m_axi_ctrl_bready  = bready_q;
  assign m_axi_ctrl_arvalid = arvalid_q;
  assign m_axi_ctrl_araddr  = araddr_q;
  assign m_axi_ctrl_rready  = rready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_resp           = rsp_resp_q;
  assign busy               = (state_q != ST_IDLE);
  assign timeout_o          = timeout_q;

endmodule

// File: doc/i2s_tx_10xe_axil_ctrl_master.md
Name: i2s_tx_10xe_axil_ctrl_master

Overview:
- AXI4-Lite master and two-port arbiter that owns the I2S transmitter's control bus (s_axi_ctrl_*).
- Port 0 (config sequencer) and port 1 (status/debug poller) each issue single-beat register reads and writes.
- The block grants one requester at a time (round-robin), runs the AXI4-Lite transaction to completion, and returns the response to the granted requester.
- At most one transaction is outstanding at any time. A watchdog flags slave non-response.

Parameters:
- ADDR_W, 8, address width (matches the control bus).
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 256, cycles spent waiting in any AXI phase before timeout_o pulses (range 2..65535).

Ports:
- s_axi_ctrl_aclk  in  1  clock.
- s_axi_ctrl_areset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit n = port n.
- req_ready  out  2  per-port request accept.
- req_wr  in  2  per-port transaction type: 1 = write, 0 = read.
- req_addr  in  2*ADDR_W  per-port address, packed with port n at [n*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-port write data, packed.
- rsp_valid  out  2  one-cycle completion pulse to the owning port.
- rsp_rdata  out  DATA_W  read data; valid only with rsp_valid.
- rsp_resp  out  2  BRESP/RRESP of the completed transaction.
- m_axi_ctrl_awvalid/awready/awaddr  out/in/out  1/1/ADDR_W  AW channel.
- m_axi_ctrl_wvalid/wready/wdata  out/in/out  1/1/DATA_W  W channel.
- m_axi_ctrl_bvalid/bready/bresp  in/out/in  1/1/2  B channel.
- m_axi_ctrl_arvalid/arready/araddr  out/in/out  1/1/ADDR_W  AR channel.
- m_axi_ctrl_rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_W/2  R channel.
- busy  out  1  high whenever state != IDLE.
- timeout_o  out  1  one-cycle pulse when a phase exceeds TIMEOUT_CYCLES.

Behaviour:
- Reset values: all AXI valid/ready outputs 0; awaddr, araddr, wdata 0; req_ready 0; rsp_valid 0; rsp_rdata 0; rsp_resp 0; busy 0; timeout_o 0. Round-robin pointer starts favouring port 0. Reset mid-transaction abandons the transfer; the bench must also reset the slave.
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - grant is combinational round-robin over req_valid. With a single requester, it is granted. With both requesting, the port that was not granted last wins.
  - req_ready[g] = 1 only in IDLE for the granted port. Acceptance is req_valid[g] & req_ready[g].
  - On acceptance, register the addr/wdata/type and owner g, then go to WR or RD_ADDR.
- WR:
  - awvalid and wvalid assert 1 cycle after acceptance.
  - Each valid drops independently on its own handshake; awaddr/wdata are held stable while the corresponding valid is high.
  - When both handshakes are done (same or different cycles), go to WR_RESP with bready = 1.
- WR_RESP: on bvalid & bready, capture bresp, drop bready, go to DONE.
- RD_ADDR: arvalid held until arready; then go to RD_DATA with rready = 1.
- RD_DATA: on rvalid & rready, capture rdata/rresp, drop rready, go to DONE.
- DONE:
  - rsp_valid[owner] = 1 for exactly one cycle, with rsp_rdata/rsp_resp. rsp_rdata is 0 for writes.
  - Update the round-robin pointer to owner; return to IDLE.
  - A new grant is possible on the following cycle.
- Minimum latency with a zero-wait slave, from the acceptance cycle:
  - write: AW/W at +1, B at +2, rsp_valid at +3.
  - read: AR at +1, R at +2, rsp_valid at +3.
- Watchdog:
  - A counter clears on every state change and increments while in WR/WR_RESP/RD_ADDR/RD_DATA.
  - Reaching TIMEOUT_CYCLES pulses timeout_o once and saturates. The FSM keeps waiting; it never drops valid without a handshake.
- No backpressure on rsp. Requesters must accept the rsp_valid pulse.
- Non-OKAY responses are passed through unchanged; there is no retry.
- Simultaneous AW and W handshake in the same cycle is legal and equivalent to sequential handshakes.

Decomposition:
- Package i2s_tx_10xe_axil_pkg:
  - state enum.
  - response constants OKAY = 2'b00, SLVERR = 2'b10.
  - ADDR_W/DATA_W defaults.
  - request struct {wr, addr, wdata}.
- Sub-module i2s_tx_10xe_rr_arb2: 2-input round-robin arbiter with combinational grant and a pointer update input.

Test Plan:
- Port 0 writes 0x1234_5678 to 0x08; zero-wait slave, bresp = 00 -> AW/W at +1, bready handshake at +2, rsp_valid = 2'b01 at +3 with resp 00, rdata 0.
- Port 1 reads 0x0C; slave holds arready low 3 cycles, returns 0xDEAD_BEEF, rresp = 10 -> araddr stable 0x0C throughout the wait; rsp_valid = 2'b10, rdata 0xDEAD_BEEF, resp 10.
- Both ports continuously request 4 writes each -> grants alternate 0,1,0,1..., no port starved; busy low for exactly 1 cycle between transactions.
- Write where slave asserts wready 2 cycles before awready -> wvalid drops first, awvalid held; single B accepted; one rsp_valid pulse.
- Slave never asserts arready with TIMEOUT_CYCLES = 16 -> timeout_o pulses once at cycle 16 of RD_ADDR; arvalid stays high; releasing arready later completes normally.
- Assert s_axi_ctrl_areset during WR_RESP -> next cycle all outputs at reset values; grant pointer favours port 0.
